siso_shift_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one serial-in/serial-out shift chain between two parallel-word requesters.
- Each granted word is captured, driven onto the chain input LSB-first (one bit per clock), then held off for DEPTH cycles so the last bit clears the chain before the next frame.
- Sits directly in front of the SISO shift register: `sout` drives its serial input, `done` reports that a frame has fully drained out of it.

---
 rtl/siso_shift_arbiter_if.sv | 26 ++
 rtl/siso_shift_arbiter.sv | 123 ++++++++++++
 tb/tb_siso_shift_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/siso_shift_arbiter_if.sv
// Handshake and serial-stream bundle between two word requesters and the shift-chain arbiter.
interface siso_shift_arbiter_if #(
    parameter int unsigned WIDTH = 8
);
    logic             req0;
    logic             req1;
    logic [WIDTH-1:0] data0;
    logic [WIDTH-1:0] data1;
    logic             gnt0;
    logic             gnt1;
    logic             sout;
    logic             sen;
    logic             owner;
    logic             busy;
    logic             done;

    modport master (
        output req0, req1, data0, data1,
        input  gnt0, gnt1, sout, sen, owner, busy, done
    );

    modport slave (
        input  req0, req1, data0, data1,
        output gnt0, gnt1, sout, sen, owner, busy, done
    );
endinterface

// File: rtl/siso_shift_arbiter.sv
// Round-robin arbiter that serialises one granted word LSB-first into a SISO chain,
// then idles DEPTH cycles so the frame drains before the next grant.
module siso_shift_arbiter #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input logic                 i_clk,
    input logic                 i_rst_n,
    siso_shift_arbiter_if.slave io_bus
);
    localparam int unsigned MAXWD = (WIDTH > DEPTH) ? WIDTH : DEPTH;
    localparam int unsigned CW    = $clog2(MAXWD + 1);
    localparam logic [CW-1:0] CNT_W = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_D = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_1 = CW'(1);

    typedef enum logic [1:0] {StIdle, StShift, StFlush} state_t;

    state_t           r_state, w_state;
    logic [CW-1:0]    r_cnt, w_cnt;
    logic [WIDTH-1:0] r_shadow, w_shadow;
    logic             r_ptr, w_ptr;
    logic             r_gnt0, w_gnt0;
    logic             r_gnt1, w_gnt1;
    logic             r_sout, w_sout;
    logic             r_sen, w_sen;
    logic             r_owner, w_owner;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             w_pick1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state  <= StIdle;
            r_cnt    <= '0;
            r_shadow <= '0;
            r_ptr    <= 1'b1;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_sout   <= 1'b0;
            r_sen    <= 1'b0;
            r_owner  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            r_state  <= w_state;
            r_cnt    <= w_cnt;
            r_shadow <= w_shadow;
            r_ptr    <= w_ptr;
            r_gnt0   <= w_gnt0;
            r_gnt1   <= w_gnt1;
            r_sout   <= w_sout;
            r_sen    <= w_sen;
            r_owner  <= w_owner;
            r_busy   <= w_busy;
            r_done   <= w_done;
        end
    end

    always_comb begin
        w_state  = r_state;
        w_cnt    = r_cnt;
        w_shadow = r_shadow;
        w_ptr    = r_ptr;
        w_gnt0   = 1'b0;
        w_gnt1   = 1'b0;
        w_sout   = 1'b0;
        w_sen    = 1'b0;
        w_owner  = r_owner;
        w_busy   = r_busy;
        w_done   = 1'b0;
        // Requester 1 wins when alone, or on a tie when requester 0 was served last.
        w_pick1  = io_bus.req1 & (~io_bus.req0 | ~r_ptr);

        unique case (r_state)
            StIdle: begin
                if (io_bus.req0 || io_bus.req1) begin
                    // Bit 0 goes out now; the shadow keeps the rest pre-shifted.
                    w_shadow = w_pick1 ? (io_bus.data1 >> 1) : (io_bus.data0 >> 1);
                    w_sout   = w_pick1 ? io_bus.data1[0] : io_bus.data0[0];
                    w_gnt0   = ~w_pick1;
                    w_gnt1   = w_pick1;
                    w_owner  = w_pick1;
                    w_ptr    = w_pick1;
                    w_sen    = 1'b1;
                    w_busy   = 1'b1;
                    w_cnt    = CNT_1;
                    w_state  = StShift;
                end
            end
            StShift: begin
                if (r_cnt == CNT_W) begin
                    w_cnt   = CNT_1;
                    w_state = StFlush;
                end else begin
                    w_sout   = r_shadow[0];
                    w_shadow = r_shadow >> 1;
                    w_sen    = 1'b1;
                    w_cnt    = r_cnt + CNT_1;
                end
            end
            StFlush: begin
                if (r_cnt == CNT_D) begin
                    w_done  = 1'b1;
                    w_busy  = 1'b0;
                    w_cnt   = '0;
                    w_state = StIdle;
                end else begin
                    w_cnt = r_cnt + CNT_1;
                end
            end
            default: w_state = StIdle;
        endcase
    end

    assign io_bus.gnt0  = r_gnt0;
    assign io_bus.gnt1  = r_gnt1;
    assign io_bus.sout  = r_sout;
    assign io_bus.sen   = r_sen;
    assign io_bus.owner = r_owner;
    assign io_bus.busy  = r_busy;
    assign io_bus.done  = r_done;
endmodule

// File: tb/tb_siso_shift_arbiter.sv
// Bench for siso_shift_arbiter: directed requests feed an expected-frame queue that a
// negedge monitor drains on each grant/done, alongside a model of the downstream chain.
module tb_siso_shift_arbiter;
    localparam int unsigned WIDTH  = 8;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned PERIOD = WIDTH + DEPTH + 1;

    typedef struct packed {
        logic             id;
        logic [WIDTH-1:0] word;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    siso_shift_arbiter_if #(.WIDTH(WIDTH)) bus ();

    siso_shift_arbiter #(
        .WIDTH(WIDTH),
        .DEPTH(DEPTH)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .io_bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Downstream SISO chain: DEPTH flops from serial input to serial output.
    logic [DEPTH-1:0] chain, chain_v;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain   <= '0;
            chain_v <= '0;
        end else begin
            chain   <= (chain << 1) | DEPTH'(bus.sout);
            chain_v <= (chain_v << 1) | DEPTH'(bus.sen);
        end
    end

    exp_t             exp_q[$];
    exp_t             cur;
    bit               inflight = 1'b0;
    int               nbits    = 0;
    int               cbits    = 0;
    int               gnt_cyc  = 0;
    logic [WIDTH-1:0] got_word   = '0;
    logic [WIDTH-1:0] chain_word = '0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push_exp(input logic id, input logic [WIDTH-1:0] w);
        exp_t e;
        e.id   = id;
        e.word = w;
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            inflight = 1'b0;
            nbits    = 0;
            cbits    = 0;
        end else begin
            if (bus.gnt0 || bus.gnt1) begin
                check("gnt_onehot", 32'(bus.gnt0 & bus.gnt1), 32'd0);
                check("gnt_while_busy", 32'(inflight), 32'd0);
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_gnt: got gnt0=%b gnt1=%b expected no grant",
                             bus.gnt0, bus.gnt1);
                end else begin
                    cur = exp_q.pop_front();
                    check("gnt_id", 32'(bus.gnt1), 32'(cur.id));
                    check("owner", 32'(bus.owner), 32'(cur.id));
                    check("busy_at_gnt", 32'(bus.busy), 32'd1);
                    inflight = 1'b1;
                    gnt_cyc  = cyc;
                    nbits    = 0;
                    cbits    = 0;
                end
            end
            if (bus.sen) begin
                got_word = {bus.sout, got_word[WIDTH-1:1]};
                nbits++;
            end
            if (chain_v[DEPTH-1]) begin
                chain_word = {chain[DEPTH-1], chain_word[WIDTH-1:1]};
                cbits++;
            end
            if (bus.done) begin
                if (!inflight) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL spurious_done: got done=1 expected 0 (cycle %0d)", cyc);
                end else begin
                    check("frame_word", 32'(got_word), 32'(cur.word));
                    check("frame_len", 32'(nbits), 32'(WIDTH));
                    check("chain_word", 32'(chain_word), 32'(cur.word));
                    check("chain_len", 32'(cbits), 32'(WIDTH));
                    check("done_latency", 32'(cyc - gnt_cyc), 32'(WIDTH + DEPTH));
                    check("busy_at_done", 32'(bus.busy), 32'd0);
                    inflight = 1'b0;
                end
            end
        end
    end

    task automatic wait_gnt(output int c, output logic g1);
        int n = 0;
        c  = -1;
        g1 = 1'b0;
        while (c < 0 && n < 60) begin
            @(negedge clk);
            n++;
            if (bus.gnt0 || bus.gnt1) begin
                c  = cyc;
                g1 = bus.gnt1;
            end
        end
        if (c < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL gnt_timeout: got no grant expected one within 60 cycles");
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((bus.busy || inflight) && n < 100);
        if (bus.busy || inflight) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: got busy=%b expected 0 within 100 cycles", bus.busy);
        end
    endtask

    initial begin
        int   c, c0, prev;
        logic g1;
        bus.req0  = 1'b0;
        bus.req1  = 1'b0;
        bus.data0 = '0;
        bus.data1 = '0;

        // Reset held with toggling requests, then a tie on release.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            bus.req0 = i[0];
            bus.req1 = ~i[0];
            check("reset_outputs", 32'({bus.gnt0, bus.gnt1, bus.sout, bus.sen, bus.owner,
                                        bus.busy, bus.done}), 32'd0);
        end
        bus.data0 = 8'h3C;
        bus.data1 = 8'hC3;
        bus.req0  = 1'b1;
        bus.req1  = 1'b1;
        push_exp(1'b0, 8'h3C);
        push_exp(1'b1, 8'hC3);
        @(negedge clk);
        rst_n = 1'b1;
        wait_gnt(c, g1);
        check("tie_first", 32'(g1), 32'd0);
        bus.req0 = 1'b0;
        wait_gnt(c, g1);
        check("tie_second", 32'(g1), 32'd1);
        bus.req1 = 1'b0;
        wait_idle();

        // Round-robin under continuous requests.
        bus.data0 = 8'h0F;
        bus.data1 = 8'hF0;
        for (int k = 0; k < 4; k++) push_exp(k[0], k[0] ? 8'hF0 : 8'h0F);
        bus.req0 = 1'b1;
        bus.req1 = 1'b1;
        prev = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(c, g1);
            check("rr_order", 32'(g1), 32'(k[0]));
            if (k > 0) check("rr_spacing", 32'(c - prev), 32'(PERIOD));
            prev = c;
        end
        bus.req0 = 1'b0;
        bus.req1 = 1'b0;
        wait_idle();

        // Single frame.
        bus.data0 = 8'hA5;
        push_exp(1'b0, 8'hA5);
        bus.req0 = 1'b1;
        wait_gnt(c, g1);
        bus.req0 = 1'b0;
        wait_idle();

        // Late request; data0 changes after the grant.
        bus.data0 = 8'h5A;
        push_exp(1'b0, 8'h5A);
        bus.req0 = 1'b1;
        wait_gnt(c0, g1);
        bus.req0  = 1'b0;
        bus.data0 = 8'hFF;
        repeat (3) @(negedge clk);
        bus.data1 = 8'h81;
        bus.req1  = 1'b1;
        push_exp(1'b1, 8'h81);
        wait_gnt(c, g1);
        check("late_gnt_cycle", 32'(c - c0), 32'(PERIOD));
        bus.req1 = 1'b0;
        wait_idle();

        // Reset in the middle of a frame with req1 pending.
        bus.data0 = 8'hFF;
        push_exp(1'b0, 8'hFF);
        bus.req0 = 1'b1;
        wait_gnt(c0, g1);
        bus.req0  = 1'b0;
        bus.data1 = 8'h66;
        bus.req1  = 1'b1;
        repeat (4) @(posedge clk);
        #2;
        check("pre_reset_bit4", 32'({bus.sen, bus.sout}), 32'd3);
        rst_n = 1'b0;
        #1;
        check("async_reset", 32'({bus.gnt0, bus.gnt1, bus.sout, bus.sen, bus.owner,
                                  bus.busy, bus.done}), 32'd0);
        repeat (2) @(negedge clk);
        push_exp(1'b1, 8'h66);
        rst_n = 1'b1;
        wait_gnt(c, g1);
        check("post_reset_winner", 32'(g1), 32'd1);
        bus.req1 = 1'b0;
        wait_idle();

        // Request pulse that no edge samples.
        @(posedge clk);
        #2 bus.req0 = 1'b1;
        #2 bus.req0 = 1'b0;
        repeat (5) @(negedge clk);
        check("withdrawn_idle", 32'({bus.busy, bus.sen, bus.gnt0, bus.gnt1}), 32'd0);

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        check("no_inflight", 32'(inflight), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got simulation still running expected completion");
        $fatal(1);
    end
endmodule
